// File: rtl/dense_layer_mc.sv
// Fully-connected classifier stage: streams IN_SIZE features, MACs them against a weight ROM for all classes, adds saturating bias, then argmax.
// Latency: done pulses NUM_CLASSES+1 clocks after the clock edge that accepts the last feature.
// Backpressure: feat_ready is high only in COMPUTE; feat_valid low stalls the MAC indefinitely; start is only honoured in IDLE.
// ROM contents come in as parameter images, so the block elaborates without external files.
// W_INIT entry c*IN_SIZE+i holds weight(class c, feature i); B_INIT entry c holds bias(class c).
module dense_layer_mc #(
  parameter int IN_SIZE     = 169,
  parameter int NUM_CLASSES = 4,
  parameter int FEAT_W      = 16,
  parameter int WGT_W       = 8,
  parameter int BIAS_W      = 16,
  parameter int ACC_W       = 32,
  parameter logic [NUM_CLASSES*IN_SIZE*WGT_W-1:0] W_INIT = '0,
  parameter logic [NUM_CLASSES*BIAS_W-1:0]        B_INIT = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           feat_valid,
  input  logic signed [FEAT_W-1:0]       feat_in,
  output logic                           feat_ready,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_CLASSES*ACC_W-1:0]   scores,
  output logic [$clog2(NUM_CLASSES)-1:0] class_idx,
  output logic signed [ACC_W-1:0]        max_score
);

  localparam int CNT_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam int PRD_W = FEAT_W + WGT_W;
  localparam logic signed [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_BIAS, S_ARGMAX} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_feat_ready;
  logic                    r_done;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic signed [ACC_W-1:0] r_acc   [NUM_CLASSES];
  logic signed [ACC_W-1:0] r_score [NUM_CLASSES];
  logic signed [ACC_W-1:0] r_run_max;
  logic [IDX_W-1:0]        r_run_idx;
  logic [IDX_W-1:0]        r_class_idx;
  logic signed [ACC_W-1:0] r_max_score;

  logic                    w_accept;
  logic                    w_last_feat;
  logic                    w_last_cls;
  logic                    w_take;
  logic signed [ACC_W-1:0] w_cur;
  logic signed [WGT_W-1:0] w_wgt  [NUM_CLASSES];
  logic signed [BIAS_W-1:0] w_bias [NUM_CLASSES];
  logic signed [PRD_W-1:0] w_prod [NUM_CLASSES];
  logic signed [ACC_W:0]   w_sum  [NUM_CLASSES];
  logic signed [ACC_W-1:0] w_sat  [NUM_CLASSES];

  assign w_accept    = (r_state == S_COMPUTE) && feat_valid && r_feat_ready;
  assign w_last_feat = (r_cnt == CNT_W'(IN_SIZE - 1));
  assign w_last_cls  = (r_idx == IDX_W'(NUM_CLASSES - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: start only matters in IDLE, the MAC phase ends on the last accepted feature.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_COMPUTE;
      S_COMPUTE: if (w_accept && w_last_feat) w_next = S_BIAS;
      S_BIAS:    w_next = S_ARGMAX;
      S_ARGMAX:  if (w_last_cls) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and held result registers.
  always_comb begin
    busy       = (r_state != S_IDLE);
    feat_ready = r_feat_ready;
    done       = r_done;
    class_idx  = r_class_idx;
    max_score  = r_max_score;
    scores     = '0;
    for (int c = 0; c < NUM_CLASSES; c++) scores[c*ACC_W +: ACC_W] = r_score[c];
  end

  // ROM lookup, per-class product, and saturating bias add; the sum is one bit wider to expose overflow.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      w_wgt[c]  = W_INIT[(c*IN_SIZE + int'(r_cnt))*WGT_W +: WGT_W];
      w_bias[c] = B_INIT[c*BIAS_W +: BIAS_W];
      w_prod[c] = feat_in * w_wgt[c];
      w_sum[c]  = (ACC_W+1)'(r_acc[c]) + (ACC_W+1)'(w_bias[c]);
      if (w_sum[c][ACC_W] != w_sum[c][ACC_W-1]) w_sat[c] = w_sum[c][ACC_W] ? SMIN : SMAX;
      else                                      w_sat[c] = w_sum[c][ACC_W-1:0];
    end
  end

  // Argmax step: class 0 seeds the running max; later classes win only when strictly greater.
  always_comb begin
    w_cur  = r_score[r_idx];
    w_take = (r_idx == '0) || (w_cur > r_run_max);
  end

  // Datapath: accumulators, counters, scores, argmax tracking and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_feat_ready <= 1'b0;
      r_done       <= 1'b0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_run_max    <= '0;
      r_run_idx    <= '0;
      r_class_idx  <= '0;
      r_max_score  <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        r_acc[c]   <= '0;
        r_score[c] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt        <= '0;
            r_feat_ready <= 1'b1;
            for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
          end
        end
        S_COMPUTE: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= r_acc[c] + ACC_W'(w_prod[c]);
            if (w_last_feat) r_feat_ready <= 1'b0;
          end
        end
        S_BIAS: begin
          r_idx <= '0;
          for (int c = 0; c < NUM_CLASSES; c++) r_score[c] <= w_sat[c];
        end
        S_ARGMAX: begin
          r_idx <= r_idx + IDX_W'(1);
          if (w_take) begin
            r_run_max <= w_cur;
            r_run_idx <= r_idx;
          end
          if (w_last_cls) begin
            r_class_idx <= w_take ? r_idx : r_run_idx;
            r_max_score <= w_take ? w_cur : r_run_max;
            r_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
